// File: rtl/api_chip_slave.sv
// SPI responder for the API serial bus: oversamples load/sck/mosi in the clk domain,
// deframes 32-bit work words and shifts queued reply words back out on miso.
module api_chip_slave #(
    parameter int unsigned WORK_LEN    = 23,
    parameter int unsigned REPLY_LEN   = 2,
    parameter int unsigned REPLY_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           sck,
    input  logic                           mosi,
    output logic                           miso,
    output logic [31:0]                    rx_word,
    output logic                           rx_valid,
    output logic                           rx_done,
    output logic                           rx_err,
    input  logic [31:0]                    reply_din,
    input  logic                           reply_push,
    output logic                           reply_full,
    output logic [$clog2(REPLY_DEPTH):0]   reply_cnt
);

    localparam int unsigned AW = $clog2(REPLY_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0]   FrameBits = 16'(WORK_LEN * 32);
    localparam logic [10:0]   WordLim   = 11'(WORK_LEN);
    localparam logic [11:0]   ReplyLim  = 12'(REPLY_LEN);
    localparam logic [CW-1:0] DepthC    = CW'(REPLY_DEPTH);

    typedef enum logic {StIdle, StShift} state_e;

    // [0],[1] synchronizer stages, [2] previous synchronized value for edge detection
    logic [2:0] load_q, sck_q;
    logic [1:0] mosi_q;

    state_e      state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [31:0] rx_sr_q, rx_sr_d;
    logic [31:0] tx_sr_q, tx_sr_d;
    logic [31:0] rx_word_q, rx_word_d;
    logic        miso_q, miso_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_done_q, rx_done_d;
    logic        rx_err_q, rx_err_d;

    logic [31:0]   mem_q [REPLY_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        load_rise, load_fall, sck_rise, sck_fall;
    logic        reply_take, fifo_empty, fifo_full, pop, push_ok;
    logic [31:0] reply_word;
    logic [11:0] tx_next_idx;

    assign load_rise = load_q[1] & ~load_q[2];
    assign load_fall = ~load_q[1] & load_q[2];
    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];

    assign fifo_empty  = (cnt_q == '0);
    assign fifo_full   = (cnt_q == DepthC);
    assign reply_word  = fifo_empty ? 32'h0000_0000 : mem_q[rd_ptr_q];
    assign pop         = reply_take & ~fifo_empty;
    assign push_ok     = reply_push & (~fifo_full | pop);
    assign tx_next_idx = {1'b0, tx_cnt_q[15:5]} + 12'd1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        rx_word_d  = rx_word_q;
        miso_d     = miso_q;
        rx_valid_d = 1'b0;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;
        reply_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                tx_cnt_d  = '0;
                miso_d    = 1'b0;
                if (load_rise) begin
                    state_d    = StShift;
                    reply_take = 1'b1;
                    tx_sr_d    = reply_word;
                    miso_d     = reply_word[31];
                end
            end
            StShift: begin
                // A load fall takes priority over any coincident sck edge
                if (load_fall) begin
                    state_d   = StIdle;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    tx_cnt_d  = '0;
                    if (bit_cnt_q == FrameBits) rx_done_d = 1'b1;
                    else                        rx_err_d  = 1'b1;
                end else if (sck_rise) begin
                    rx_sr_d = {rx_sr_q[30:0], mosi_q[1]};
                    if (bit_cnt_q != 16'hFFFF) begin
                        bit_cnt_d = bit_cnt_q + 16'd1;
                        if (bit_cnt_q[4:0] == 5'd31 && bit_cnt_q[15:5] < WordLim) begin
                            rx_valid_d = 1'b1;
                            rx_word_d  = rx_sr_d;
                        end
                    end
                end else if (sck_fall) begin
                    tx_sr_d = {tx_sr_q[30:0], 1'b0};
                    if (tx_cnt_q[4:0] == 5'd31 && tx_next_idx < ReplyLim) begin
                        reply_take = 1'b1;
                        tx_sr_d    = reply_word;
                    end
                    if (tx_cnt_q != 16'hFFFF) tx_cnt_d = tx_cnt_q + 16'd1;
                    miso_d = tx_sr_d[31];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    end

    // Load chain resets high so a load still asserted across reset cannot start a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q     <= 3'b111;
            sck_q      <= 3'b000;
            mosi_q     <= 2'b00;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            tx_cnt_q   <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            rx_word_q  <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            load_q     <= {load_q[1:0], load};
            sck_q      <= {sck_q[1:0], sck};
            mosi_q     <= {mosi_q[0], mosi};
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            rx_word_q  <= rx_word_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= reply_din;
    end

    assign miso       = miso_q;
    assign rx_word    = rx_word_q;
    assign rx_valid   = rx_valid_q;
    assign rx_done    = rx_done_q;
    assign rx_err     = rx_err_q;
    assign reply_full = fifo_full;
    assign reply_cnt  = cnt_q;

endmodule

// File: tb/tb_api_chip_slave.sv
// Directed bench for api_chip_slave: acts as the SPI master, models the reply FIFO.
module tb_api_chip_slave;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst, load, sck, mosi, miso;
    logic [31:0] rx_word, reply_din;
    logic        rx_valid, rx_done, rx_err, reply_push, reply_full;
    logic [2:0]  reply_cnt;

    api_chip_slave #(.WORK_LEN(23), .REPLY_LEN(2), .REPLY_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .load(load), .sck(sck), .mosi(mosi), .miso(miso),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_done(rx_done), .rx_err(rx_err),
        .reply_din(reply_din), .reply_push(reply_push), .reply_full(reply_full),
        .reply_cnt(reply_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] rxq [$];
    logic [31:0] model_q [$];
    int tot_done = 0;
    int tot_err = 0;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_word);
        if (rx_done)  tot_done = tot_done + 1;
        if (rx_err)   tot_err = tot_err + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        @(negedge clk);
        reply_din  = w;
        reply_push = 1'b1;
        @(negedge clk);
        reply_push = 1'b0;
        if (model_q.size() < 4) model_q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load = 1'b0; sck = 1'b0; mosi = 1'b0; reply_push = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        repeat (4) @(negedge clk);
    endtask

    // Runs one frame as the master; abort_at >= 0 asserts rst at that bit instead.
    task automatic run_frame(input int nbits, input bit push_at_start, input logic [31:0] pw,
                             input int abort_at, output int nv, output int nbad,
                             output int nd, output int ne, output int nm);
        logic [31:0] exp_tx [2];
        logic [31:0] wv;
        int base_v, base_d, base_e, w;
        bit aborted;
        base_v = rxq.size(); base_d = tot_done; base_e = tot_err;
        nm = 0; aborted = 1'b0;
        for (int k = 0; k < 2; k++)
            exp_tx[k] = (model_q.size() > 0) ? model_q.pop_front() : 32'h0;
        if (push_at_start) model_q.push_back(pw);
        @(negedge clk);
        load = 1'b1; sck = 1'b0;
        if (push_at_start) begin
            @(posedge clk); @(posedge clk);
            @(negedge clk);
            reply_din = pw; reply_push = 1'b1;
            @(negedge clk);
            reply_push = 1'b0;
            check("cnt_push_pop", 32'(reply_cnt), 32'd4);
            check("full_push_pop", 32'(reply_full), 32'd1);
        end
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b == abort_at) begin
                rst = 1'b1; load = 1'b0; sck = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                model_q.delete();
                repeat (10) @(negedge clk);
                aborted = 1'b1;
                break;
            end
            w = b / 32;
            wv = (w < 23) ? 32'hA500_0000 + 32'(w) : 32'hFFFF_FFFF;
            mosi = wv[31 - (b % 32)];
            repeat (HALF) @(negedge clk);
            wv = (w < 2) ? exp_tx[w] : 32'h0;
            if (miso !== wv[31 - (b % 32)]) nm++;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        if (!aborted) begin
            repeat (HALF) @(negedge clk);
            load = 1'b0;
            repeat (8) @(negedge clk);
        end
        nv = rxq.size() - base_v;
        nbad = 0;
        for (int i = 0; i < nv; i++)
            if (rxq[base_v + i] !== 32'hA500_0000 + 32'(i)) nbad++;
        nd = tot_done - base_d;
        ne = tot_err - base_e;
    endtask

    typedef struct {
        int nbits;
        int npush;
        int exp_valid;
        int exp_done;
        int exp_err;
    } frame_vec_t;

    initial begin
        frame_vec_t vecs [6];
        logic [31:0] pw [2];
        int nv, nbad, nd, ne, nm;

        vecs[0] = '{736, 2, 23, 1, 0};
        vecs[1] = '{700, 0, 21, 0, 1};
        vecs[2] = '{740, 0, 23, 0, 1};
        vecs[3] = '{736, 0, 23, 1, 0};
        vecs[4] = '{32,  1, 1,  0, 1};
        vecs[5] = '{0,   0, 0,  0, 1};
        pw[0] = 32'h1234_5678;
        pw[1] = 32'h9ABC_DEF0;

        rst = 1'b1; load = 1'b0; sck = 1'b0; mosi = 1'b0;
        reply_push = 1'b0; reply_din = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_rx_word", rx_word, 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_rx_err", 32'(rx_err), 32'd0);
        check("rst_full", 32'(reply_full), 32'd0);
        check("rst_cnt", 32'(reply_cnt), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int p = 0; p < vecs[v].npush; p++) push_word(pw[p]);
            run_frame(vecs[v].nbits, 1'b0, 32'h0, -1, nv, nbad, nd, ne, nm);
            check($sformatf("v%0d_valid", v), 32'(nv), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_words", v), 32'(nbad), 32'd0);
            check($sformatf("v%0d_done", v), 32'(nd), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_err", v), 32'(ne), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_miso_bits", v), 32'(nm), 32'd0);
            check($sformatf("v%0d_cnt", v), 32'(reply_cnt), 32'(model_q.size()));
            check($sformatf("v%0d_miso_idle", v), 32'(miso), 32'd0);
            if (vecs[v].exp_valid > 0)
                check($sformatf("v%0d_last_word", v), rx_word,
                      32'hA500_0000 + 32'(vecs[v].exp_valid - 1));
        end

        // FIFO boundary: fifth push dropped, push coinciding with word-0 pop accepted
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'hC000_0000 + 32'(i));
        check("fill_cnt", 32'(reply_cnt), 32'd4);
        check("fill_full", 32'(reply_full), 32'd1);
        run_frame(736, 1'b1, 32'hEEEE_0001, -1, nv, nbad, nd, ne, nm);
        check("bnd1_valid", 32'(nv), 32'd23);
        check("bnd1_done", 32'(nd), 32'd1);
        check("bnd1_miso_bits", 32'(nm), 32'd0);
        check("bnd1_cnt", 32'(reply_cnt), 32'd3);
        check("bnd1_full", 32'(reply_full), 32'd0);
        run_frame(736, 1'b0, 32'h0, -1, nv, nbad, nd, ne, nm);
        check("bnd2_miso_bits", 32'(nm), 32'd0);
        check("bnd2_cnt", 32'(reply_cnt), 32'd1);
        check("bnd2_done", 32'(nd), 32'd1);

        // Reset mid-frame at bit 300
        do_reset();
        for (int i = 0; i < 3; i++) push_word(32'hD000_0000 + 32'(i));
        check("abort_pre_cnt", 32'(reply_cnt), 32'd3);
        run_frame(736, 1'b0, 32'h0, 300, nv, nbad, nd, ne, nm);
        check("abort_valid", 32'(nv), 32'd9);
        check("abort_done", 32'(nd), 32'd0);
        check("abort_err", 32'(ne), 32'd0);
        check("abort_cnt", 32'(reply_cnt), 32'd0);
        check("abort_miso", 32'(miso), 32'd0);
        run_frame(736, 1'b0, 32'h0, -1, nv, nbad, nd, ne, nm);
        check("post_valid", 32'(nv), 32'd23);
        check("post_words", 32'(nbad), 32'd0);
        check("post_done", 32'(nd), 32'd1);
        check("post_err", 32'(ne), 32'd0);
        check("post_miso_bits", 32'(nm), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
